pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_reg_if.sv | 62 ++++++
 rtl/pipe_skid_buf.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 172 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_stage_reg slice.
//   PIPE_DATA_W   default payload width in bits
//   PIPE_CNT_W    default stall counter width in bits
//   occ_state_t   occupancy of the stage: EMPTY, ONE (main only), TWO (main+skid)
// No ports; imported by the interface, the stage and its skid buffer.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CNT_W  = 16;

  // TWO is only reachable when the skid entry is built in.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Bundles the control, handshake and payload signals of one pipeline stage.
// Parameters:
//   DATA_W  payload width
//   CNT_W   stall counter width
// Signals:
//   flush      synchronous clear of the stage
//   freeze     hold stage contents, no transfers
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  stage presents a valid payload
//   out_ready  downstream accepts the payload
//   out_data   presented payload
//   stall_cnt  saturating count of backpressure cycles
// Modports:
//   master  the environment around the stage (drives inputs, sees outputs)
//   slave   the stage itself
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
);

  logic              flush;
  logic              freeze;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush,
    output freeze,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  stall_cnt
  );

  modport slave (
    input  flush,
    input  freeze,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output stall_cnt
  );

endinterface : pipe_stage_reg_if

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Data register for the second (skid) entry of pipe_stage_reg. Validity of the
// entry is tracked by the occupancy state machine in the parent; this block
// only stores the payload.
// Parameters:
//   DATA_W   payload width
//   RST_VAL  value held after reset or clear
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   clear  synchronous load of RST_VAL (takes priority over load)
//   load   capture d on the next edge
//   d      payload in
//   q      stored payload
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clear) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : pipe_skid_buf

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// One valid/ready pipeline register stage with freeze, flush and a saturating
// backpressure counter. Latency is one cycle from acceptance to presentation.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> two entries (main + skid via pipe_skid_buf);
//                                    in_ready depends only on registered state
//                                    and freeze, so there is no combinational
//                                    path from out_ready to in_ready.
//                       undefined -> single entry; in_ready looks through to
//                                    out_ready so a full entry can be replaced
//                                    in the same cycle it drains.
// Parameters:
//   DATA_W   payload width
//   RST_VAL  value loaded into data registers on reset and flush
//   CNT_W    stall counter width
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipe_stage_reg_if.slave: flush, freeze, in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data, stall_cnt
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                CNT_W   = PIPE_CNT_W
) (
  input logic             clk,
  input logic             rst_n,
  pipe_stage_reg_if.slave bus
);

  occ_state_t        state;
  occ_state_t        state_next;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_data_next;
  logic              in_ready_int;
  logic              out_valid_int;
  logic              in_fire;
  logic              out_fire;
  logic              stalled;
  logic [CNT_W-1:0]  stall_cnt;

  assign main_valid = (state != EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic [DATA_W-1:0] skid_data;

  // TWO is the only state with the skid entry occupied; decoded straight
  // from the state register, so in_ready below is register-driven.
  assign skid_valid = (state == TWO);

  // rst_n gates in_ready so nothing is offered as accepted during reset.
  assign in_ready_int = rst_n & ~bus.freeze & ~skid_valid;

  // A payload accepted while main is full and not draining parks in skid.
  assign skid_load = ~bus.flush & in_fire & main_valid & ~out_fire;

  pipe_skid_buf #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.flush),
    .load  (skid_load),
    .d     (bus.in_data),
    .q     (skid_data)
  );
`else
  // Single entry: accept when empty or when the current entry leaves this
  // same edge.
  assign in_ready_int = rst_n & ~bus.freeze & (~main_valid | bus.out_ready);
`endif

  assign out_valid_int = main_valid & ~bus.freeze;
  assign in_fire       = bus.in_valid & in_ready_int;
  assign out_fire      = out_valid_int & bus.out_ready;
  assign stalled       = out_valid_int & ~bus.out_ready;

  // ---------------------------------------------------------------------------
  // Occupancy state machine. freeze needs no explicit term: it already blocks
  // both in_fire and out_fire, so every branch below falls through to hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    if (bus.flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) state_next = ONE;
        end
        ONE: begin
`ifdef PIPE_STAGE_SKID_EN
          if (in_fire && !out_fire) begin
            state_next = TWO;
          end else
`endif
          if (out_fire && !in_fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) state_next = ONE;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Main entry data. It is never cleared on drain, so out_data keeps showing
  // the last payload while out_valid is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    main_data_next = main_data;
    if (bus.flush) begin
      main_data_next = RST_VAL;
    end
`ifdef PIPE_STAGE_SKID_EN
    // Skid moves forward on the same edge main drains.
    else if (out_fire && skid_valid) begin
      main_data_next = skid_data;
    end
`endif
    else if (in_fire && (!main_valid || out_fire)) begin
      main_data_next = bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data register is reset as well as the valid state, because
    // out_data must read RST_VAL straight out of reset, not just be ignored.
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= RST_VAL;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      state     <= state_next;
      main_data <= main_data_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Backpressure counter: counts presented-but-refused cycles and sticks at
  // all-ones. Flush and freeze do not clear it; freeze simply stops counting
  // because out_valid is forced low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = main_data;
  assign bus.stall_cnt = stall_cnt;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. The reference model keeps the stage
// contents as a plain queue with a capacity of one (or two with the skid
// entry); accepted payloads are pushed, transferred payloads are popped. A
// monitor on the falling edge compares every DUT output with the model.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DW  = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] RV  = 32'hDEAD_BEEF;
  localparam int          SAT = (1 << CW) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int          CAP = 2;
`else
  localparam int          CAP = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  pipe_stage_reg #(
    .DATA_W  (DW),
    .RST_VAL (RV),
    .CNT_W   (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] held[$];
  logic [31:0] shown   = RV;
  int          stall_m = 0;
  int          seen_77 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    if (!rst_n || bus.freeze) return 1'b0;
    if (CAP == 2) return held.size() < 2;
    return (held.size() == 0) || bus.out_ready;
  endfunction

  function automatic logic m_ovalid();
    return rst_n && !bus.freeze && (held.size() > 0);
  endfunction

  // Model update on every rising edge, using only bench-driven inputs.
  always @(posedge clk) begin
    logic rdy;
    logic ov;
    if (rst_n) begin
      rdy = m_ready();
      ov  = m_ovalid();
      if (ov && !bus.out_ready && stall_m < SAT) stall_m++;
      if (bus.flush) begin
        held.delete();
        shown = RV;
      end else begin
        if (ov && bus.out_ready) void'(held.pop_front());
        if (bus.in_valid && rdy) held.push_back(bus.in_data);
        if (held.size() > 0) shown = held[0];
      end
    end
  end

  always @(negedge rst_n) begin
    held.delete();
    shown   = RV;
    stall_m = 0;
  end

  // Monitor: compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    check("in_ready",  {63'd0, bus.in_ready},  {63'd0, m_ready()});
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_ovalid()});
    if (bus.out_valid) check("out_data_valid", {32'd0, bus.out_data}, {32'd0, held[0]});
    else               check("out_data_hold",  {32'd0, bus.out_data}, {32'd0, shown});
    check("stall_cnt", {60'd0, bus.stall_cnt}, 64'(stall_m));
    if (bus.out_valid && bus.out_ready && bus.out_data == 32'h77) seen_77++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.freeze   = 1'b0;
    rst_n        = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.freeze    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) step();

    // Reset state.
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
    check("rst_out_data",  {32'd0, bus.out_data},  {32'd0, RV});
    check("rst_stall",     {60'd0, bus.stall_cnt}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);
    step();

    // Stream 1..8, latency 1, one per cycle.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(i);
      step();
      check("stream_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stream_data",  {32'd0, bus.out_data},  64'(i));
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_drained", {63'd0, bus.out_valid}, 64'd0);
    check("stream_hold",    {32'd0, bus.out_data},  64'd8);

    // Backpressure: hold 0xA5A5A5A5 for five refused cycles.
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA5A5_A5A5;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    check("bp_stall5",    {60'd0, bus.stall_cnt}, 64'd5);
    check("bp_data",      {32'd0, bus.out_data},  {32'd0, 32'hA5A5_A5A5});
    check("bp_in_ready",  {63'd0, bus.in_ready},  64'(CAP == 2));
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    step();
    bus.in_data  = 32'h9999_9999;
    step();
    bus.in_valid = 1'b0;
    check("bp_full_ready", {63'd0, bus.in_ready}, 64'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp_next_valid", {63'd0, bus.out_valid}, 64'(CAP == 2));
    check("bp_next_data",  {32'd0, bus.out_data},
          (CAP == 2) ? 64'h1234_5678 : 64'hA5A5_A5A5);
    step();
    check("bp_one_extra", {63'd0, bus.out_valid}, 64'd0);

    // Freeze holds the entry and hides it.
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h55;
    step();
    bus.freeze  = 1'b1;
    bus.in_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_in_ready",  {63'd0, bus.in_ready},  64'd0);
      check("frz_out_valid", {63'd0, bus.out_valid}, 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.freeze   = 1'b0;
    #1;
    check("frz_release_valid", {63'd0, bus.out_valid}, 64'd1);
    check("frz_release_data",  {32'd0, bus.out_data},  64'h55);

    // Flush beats freeze and a presented input.
    seen_77      = 0;
    bus.flush    = 1'b1;
    bus.freeze   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77;
    step();
    bus.flush    = 1'b0;
    bus.freeze   = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    check("flush_data",  {32'd0, bus.out_data},  {32'd0, RV});
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("flush_no_77", 64'(seen_77), 64'd0);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.out_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.freeze    = ($urandom_range(0, 9) == 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;

    // Asynchronous reset mid-stream, between edges.
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hC0DE_0001;
    bus.out_ready = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_stall",     {60'd0, bus.stall_cnt}, 64'd0);
    check("arst_in_ready",  {63'd0, bus.in_ready},  64'd0);
    check("arst_out_data",  {32'd0, bus.out_data},  {32'd0, RV});
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;

    // Saturation of the stall counter.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h42;
    step();
    bus.in_valid = 1'b0;
    repeat (20) step();
    check("sat_stall", {60'd0, bus.stall_cnt}, 64'(SAT));
    repeat (3) step();
    check("sat_stall_hold", {60'd0, bus.stall_cnt}, 64'(SAT));
    check("sat_data",       {32'd0, bus.out_data},  64'h42);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
